// File: rtl/loader_pkg.sv
// Shared types and constants for the main-memory loader and its byte packer.
package loader_pkg;
  localparam int DEPTH  = 10024;
  localparam int ADDR_W = 14;

  localparam logic [3:0] BE_FULL = 4'b1111;
  localparam logic [3:0] BE_NONE = 4'b0000;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_FLUSH, S_READBACK, S_DRAIN, S_DONE
  } state_t;

  // Expand a 4-bit byte enable into a 32-bit data mask.
  function automatic logic [31:0] be_mask(input logic [3:0] be);
    logic [31:0] m;
    for (int i = 0; i < 4; i++) m[8*i +: 8] = {8{be[i]}};
    return m;
  endfunction
endpackage

// File: rtl/byte_packer.sv
// Little-endian 8-to-32 assembler. The outgoing word merges the byte accepted
// this cycle, so a full or eop-terminated word is presented without delay.
module byte_packer #(
  parameter int NUM_LANES = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clear,
  input  logic [7:0]             in_data,
  input  logic                   accept,
  input  logic                   eop,
  output logic [NUM_LANES*8-1:0] word,
  output logic [NUM_LANES-1:0]   be,
  output logic                   word_valid,
  output logic                   is_last
);
  import loader_pkg::*;

  localparam int LW = $clog2(NUM_LANES);

  logic [NUM_LANES-1:0][7:0] lane_q, lane_n;
  logic [NUM_LANES-1:0]      fill_q;
  logic [LW-1:0]             cnt_q;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    logic hit;
    assign hit       = accept && (cnt_q == LW'(i));
    assign lane_n[i] = hit ? in_data : lane_q[i];
    assign be[i]     = fill_q[i] | hit;
  end

  // Unfilled lanes are held at zero, so a partial word needs no extra masking.
  assign word       = lane_n;
  assign word_valid = accept && (eop || cnt_q == LW'(NUM_LANES-1));
  assign is_last    = accept && eop;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lane_q <= '0;
      fill_q <= '0;
      cnt_q  <= '0;
    end else if (clear || word_valid) begin
      lane_q <= '0;
      fill_q <= '0;
      cnt_q  <= '0;
    end else if (accept) begin
      lane_q <= lane_n;
      fill_q <= be;
      cnt_q  <= cnt_q + 1'b1;
    end
  end
endmodule

// File: rtl/main_memory_loader.sv
// Avalon-MM write master: packs a byte stream into words, writes them from a
// programmed base (wrapping at DEPTH), then reads them back into a checksum.
module main_memory_loader #(
  parameter int DEPTH  = 10024,
  parameter int ADDR_W = 14
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [14:0]       word_count,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  input  logic              in_eop,
  output logic              in_ready,
  output logic [ADDR_W-1:0] mem_address,
  output logic [3:0]        mem_byteenable,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [31:0]       mem_writedata,
  output logic              mem_clken,
  input  logic [31:0]       mem_readdata,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [14:0]       words_written,
  output logic [31:0]       checksum
);
  import loader_pkg::*;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] DEPTH_A   = ADDR_W'(DEPTH);
  localparam logic [14:0]       DEPTH_C   = 15'(DEPTH);

  state_t            state_q, state_n;
  logic              start_ok, start_bad, rd_issue, accept, term_q, rd_vld_q;
  logic [ADDR_W-1:0] base_n, wr_addr_q, rd_addr_q;
  logic [14:0]       wcount_q, rd_idx_q;
  logic [3:0]        last_be_q, rd_mask_q, rd_mask_d;
  logic [31:0]       pk_word;
  logic [3:0]        pk_be;
  logic              pk_valid, pk_last;

  function automatic logic [ADDR_W-1:0] addr_inc(input logic [ADDR_W-1:0] a);
    return (a == LAST_ADDR) ? '0 : a + 1'b1;
  endfunction

  // term_q closes the input as soon as the terminating byte is taken.
  assign in_ready = (state_q == S_LOAD) && !term_q;
  assign accept   = in_valid && in_ready;
  assign base_n   = (base_addr >= DEPTH_A) ? base_addr - DEPTH_A : base_addr;
  assign rd_issue = (state_q == S_FLUSH || state_q == S_READBACK) &&
                    (rd_idx_q != words_written);

  byte_packer #(.NUM_LANES(4)) u_packer (
    .clk        (clk),
    .reset      (reset),
    .clear      (start_ok),
    .in_data    (in_data),
    .accept     (accept),
    .eop        (in_eop),
    .word       (pk_word),
    .be         (pk_be),
    .word_valid (pk_valid),
    .is_last    (pk_last)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_n;
  end

  always_comb begin
    state_n   = state_q;
    start_ok  = 1'b0;
    start_bad = 1'b0;
    case (state_q)
      S_IDLE, S_DONE:
        if (start) begin
          if (word_count == '0 || word_count > DEPTH_C) begin
            start_bad = 1'b1;
            state_n   = S_DONE;
          end else begin
            start_ok = 1'b1;
            state_n  = S_LOAD;
          end
        end
      S_LOAD:     if (term_q) state_n = S_FLUSH;
      S_FLUSH:    state_n = S_READBACK;
      S_READBACK: if (rd_idx_q == words_written) state_n = S_DRAIN;
      S_DRAIN:    state_n = S_DONE;
      default:    state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_address    <= '0;
      mem_byteenable <= '0;
      mem_chipselect <= 1'b0;
      mem_write      <= 1'b0;
      mem_writedata  <= '0;
      mem_clken      <= 1'b1;
      busy           <= 1'b0;
      done           <= 1'b0;
      error          <= 1'b0;
      words_written  <= '0;
      checksum       <= '0;
      term_q         <= 1'b0;
      wr_addr_q      <= '0;
      rd_addr_q      <= '0;
      wcount_q       <= '0;
      rd_idx_q       <= '0;
      last_be_q      <= '0;
      rd_mask_q      <= '0;
      rd_mask_d      <= '0;
      rd_vld_q       <= 1'b0;
    end else begin
      mem_clken      <= 1'b1;
      mem_chipselect <= 1'b0;
      mem_write      <= 1'b0;
      // Readdata lags its address by one cycle; carry the mask alongside.
      rd_vld_q  <= mem_chipselect && !mem_write;
      rd_mask_d <= (mem_chipselect && !mem_write) ? rd_mask_q : BE_NONE;
      if (rd_vld_q) checksum <= checksum + (mem_readdata & be_mask(rd_mask_d));

      if (start_ok) begin
        wr_addr_q     <= base_n;
        rd_addr_q     <= base_n;
        wcount_q      <= word_count;
        rd_idx_q      <= '0;
        words_written <= '0;
        checksum      <= '0;
        term_q        <= 1'b0;
        last_be_q     <= BE_FULL;
        busy          <= 1'b1;
        done          <= 1'b0;
        error         <= 1'b0;
      end
      if (start_bad) begin
        words_written <= '0;
        error         <= 1'b1;
        done          <= 1'b1;
        busy          <= 1'b0;
      end

      if (pk_valid) begin
        mem_chipselect <= 1'b1;
        mem_write      <= 1'b1;
        mem_address    <= wr_addr_q;
        mem_writedata  <= pk_word;
        mem_byteenable <= pk_be;
        wr_addr_q      <= addr_inc(wr_addr_q);
        words_written  <= words_written + 15'd1;
        last_be_q      <= pk_be;
        if (pk_last || (words_written + 15'd1 == wcount_q)) term_q <= 1'b1;
      end

      if (rd_issue) begin
        mem_chipselect <= 1'b1;
        mem_byteenable <= BE_FULL;
        mem_address    <= rd_addr_q;
        rd_addr_q      <= addr_inc(rd_addr_q);
        rd_idx_q       <= rd_idx_q + 15'd1;
        rd_mask_q      <= (rd_idx_q + 15'd1 == words_written) ? last_be_q : BE_FULL;
      end

      if (state_q == S_DRAIN) begin
        busy <= 1'b0;
        done <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_main_memory_loader.sv
// Randomized bench: a byte-stream reference model predicts every write, read
// address, cycle position and the checksum of a load.
module tb_main_memory_loader;
  localparam int DEPTH  = 10024;
  localparam int ADDR_W = 14;

  logic              clk = 1'b0;
  logic              reset, start, in_valid, in_eop, in_ready;
  logic [ADDR_W-1:0] base_addr, mem_address;
  logic [14:0]       word_count, words_written;
  logic [7:0]        in_data;
  logic [3:0]        mem_byteenable;
  logic              mem_chipselect, mem_write, mem_clken, busy, done, error;
  logic [31:0]       mem_writedata, mem_readdata, checksum;

  int n_chk = 0, n_err = 0, cyc = 0, cs_cnt = 0;
  logic [31:0] mem [DEPTH];
  int          wa_q[$], wc_q[$], ra_q[$], rc_q[$];
  logic [31:0] wd_q[$];
  logic [3:0]  wb_q[$];
  byte unsigned pat[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  main_memory_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
    .word_count(word_count), .in_data(in_data), .in_valid(in_valid),
    .in_eop(in_eop), .in_ready(in_ready), .mem_address(mem_address),
    .mem_byteenable(mem_byteenable), .mem_chipselect(mem_chipselect),
    .mem_write(mem_write), .mem_writedata(mem_writedata), .mem_clken(mem_clken),
    .mem_readdata(mem_readdata), .busy(busy), .done(done), .error(error),
    .words_written(words_written), .checksum(checksum)
  );

  // Zero-wait-state memory: byte-enabled writes, readdata one cycle later.
  always @(posedge clk) begin
    if (mem_chipselect && mem_write)
      for (int b = 0; b < 4; b++)
        if (mem_byteenable[b]) mem[int'(mem_address)][8*b +: 8] <= mem_writedata[8*b +: 8];
    if (mem_chipselect && !mem_write) mem_readdata <= mem[int'(mem_address)];
  end

  always @(negedge clk)
    if (!reset && mem_chipselect) begin
      cs_cnt <= cs_cnt + 1;
      if (mem_write) begin
        wa_q.push_back(int'(mem_address)); wd_q.push_back(mem_writedata);
        wb_q.push_back(mem_byteenable);    wc_q.push_back(cyc);
      end else begin
        ra_q.push_back(int'(mem_address)); rc_q.push_back(cyc);
      end
    end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic fill(input int n);
    pat.delete();
    for (int i = 0; i < n; i++) pat.push_back(8'($urandom_range(255)));
  endtask

  task automatic do_load(input int b, input int cnt, input bit eop_end,
                         input int vprob, input bit poke);
    int nbytes, acc, nw, w0, r0, ptr, t, term_cyc, k, last_b;
    bit poked;
    int acc_cyc[$];
    logic [31:0] d, sum;
    nbytes = pat.size();
    acc    = (eop_end && nbytes < 4*cnt) ? nbytes : 4*cnt;
    nw     = (acc + 3) / 4;
    w0 = wa_q.size(); r0 = ra_q.size(); sum = 0;
    base_addr = ADDR_W'(b); word_count = 15'(cnt); start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk("busy_after_start", 32'(busy), 1);
    chk("done_cleared", 32'(done), 0);
    ptr = 0; t = 0; poked = 0; term_cyc = 0;
    while (ptr < acc && t < 5000) begin
      in_valid = ($urandom_range(99) < vprob);
      in_data  = pat[ptr];
      in_eop   = eop_end && (ptr == nbytes - 1);
      if (poke && !poked && ptr == 2) begin start = 1'b1; word_count = '0; poked = 1; end
      chk("in_ready_load", 32'(in_ready), 1);
      if (in_valid && in_ready) begin acc_cyc.push_back(cyc); term_cyc = cyc; ptr++; end
      @(negedge clk); start = 1'b0; t++;
    end
    in_valid = 1'b0; in_eop = 1'b0;
    chk("bytes_taken", ptr, acc);
    chk("in_ready_drop", 32'(in_ready), 0);
    t = 0;
    while (!done && t < 300) begin @(negedge clk); t++; end
    chk("done_cyc", cyc, term_cyc + 4 + nw);
    chk("busy_end", 32'(busy), 0);
    chk("error_end", 32'(error), 0);
    chk("words_written", 32'(words_written), nw);
    chk("n_writes", wa_q.size() - w0, nw);
    chk("n_reads", ra_q.size() - r0, nw);
    for (int j = 0; j < nw; j++) begin
      d = '0; k = 0;
      for (int l = 0; l < 4; l++)
        if (4*j + l < acc) begin d[8*l +: 8] = pat[4*j + l]; k++; end
      sum += d;
      last_b = (4*j + 3 < acc) ? 4*j + 3 : acc - 1;
      if (ptr == acc && w0 + j < wa_q.size()) begin
        chk("wr_addr", wa_q[w0+j], (b + j) % DEPTH);
        chk("wr_data", wd_q[w0+j], d);
        chk("wr_be", 32'(wb_q[w0+j]), (1 << k) - 1);
        chk("wr_cyc", wc_q[w0+j], acc_cyc[last_b] + 1);
      end
      if (ptr == acc && r0 + j < ra_q.size()) begin
        chk("rd_addr", ra_q[r0+j], (b + j) % DEPTH);
        chk("rd_cyc", rc_q[r0+j], term_cyc + 3 + j);
      end
    end
    chk("checksum", checksum, sum);
  endtask

  task automatic rej(input int cnt);
    int c0;
    c0 = cs_cnt;
    base_addr = ADDR_W'(5); word_count = 15'(cnt); start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk("rej_error", 32'(error), 1);
    chk("rej_done", 32'(done), 1);
    chk("rej_busy", 32'(busy), 0);
    chk("rej_words", 32'(words_written), 0);
    repeat (3) @(negedge clk);
    chk("rej_no_cs", cs_cnt - c0, 0);
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_addr"},  32'(mem_address), 0);
    chk({tag, "_be"},    32'(mem_byteenable), 0);
    chk({tag, "_strb"},  32'({mem_chipselect, mem_write}), 0);
    chk({tag, "_wdata"}, mem_writedata, 0);
    chk({tag, "_stat"},  32'({busy, done, error, in_ready}), 0);
    chk({tag, "_words"}, 32'(words_written), 0);
    chk({tag, "_csum"},  checksum, 0);
    chk({tag, "_clken"}, 32'(mem_clken), 1);
  endtask

  initial begin
    int cnt, nb, b;
    bit e;
    reset = 1'b1; start = 1'b0; base_addr = '0; word_count = '0;
    in_data = '0; in_valid = 1'b0; in_eop = 1'b0;
    for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
    repeat (2) @(negedge clk);
    chk_reset_outs("reset");
    reset = 1'b0;
    @(negedge clk);

    pat = {8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    do_load(0, 2, 0, 100, 0);
    chk("full_checksum", checksum, 32'hCCAA8866);

    pat = {8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hFF};
    do_load(40, 10, 1, 100, 0);
    chk("partial_words", 32'(words_written), 2);

    fill(12);
    do_load(DEPTH - 1, 3, 0, 100, 0);

    rej(0);
    rej(DEPTH + 1);

    fill(15);
    do_load(200, 8, 1, 50, 1);

    // Abandon a load after five bytes.
    fill(12);
    base_addr = ADDR_W'(100); word_count = 15'd3; start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int i = 0; i < 5; i++) begin in_valid = 1'b1; in_data = pat[i]; @(negedge clk); end
    in_valid = 1'b0;
    #2 reset = 1'b1;
    #1 chk_reset_outs("async_reset");
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    fill(7);
    do_load(300, 2, 1, 100, 0);

    for (int n = 0; n < 8; n++) begin
      cnt = $urandom_range(1, 5);
      e   = 1'($urandom_range(1));
      nb  = e ? $urandom_range(1, 4*cnt + 2) : 4*cnt;
      b   = ($urandom_range(1) != 0) ? $urandom_range(DEPTH - 6, DEPTH - 1)
                                     : $urandom_range(0, DEPTH - 1);
      fill(nb);
      do_load(b, cnt, e, $urandom_range(40, 100), 1'($urandom_range(1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
